// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of an asynchronous SRAM.
//
// Each transaction is one IDLE sample, WAIT_CYCLES cycles of ACCESS with the
// SRAM strobes asserted, and one DONE cycle carrying a single-cycle Ack to the
// granted port. Request inputs are sampled only in IDLE, so a requester must
// hold Req/WE/ADDR/Wdata until its Ack.
//
// Parameters:
//   WAIT_CYCLES       SRAM access cycles per transaction (legal 1..15)
// Ports:
//   i_clk             system clock, rising edge
//   i_rst             asynchronous active-high reset
//   i_req0/i_req1     access request (port 0 = CPU, port 1 = DMA/loader)
//   i_we0/i_we1       1 = write, 0 = read
//   i_addr0/i_addr1   20-bit word address
//   i_wdata0/i_wdata1 16-bit write data
//   o_ack0/o_ack1     one-cycle completion pulse
//   o_rdata           read data, held until the next read completes
//   o_gnt             index of the port owning the current/last transaction
//   o_mem_ce/ub/lb    active-low SRAM enables, tied asserted
//   o_mem_oe/o_mem_we active-low SRAM strobes
//   o_mem_addr        SRAM address
//   o_data_to_sram    SRAM write data
//   o_drive_en        high while this block drives the SRAM data bus
//   i_data_from_sram  SRAM read data

module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [19:0] i_addr0,
  input  logic [19:0] i_addr1,
  input  logic [15:0] i_wdata0,
  input  logic [15:0] i_wdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [15:0] o_rdata,
  output logic        o_gnt,
  output logic        o_mem_ce,
  output logic        o_mem_ub,
  output logic        o_mem_lb,
  output logic        o_mem_oe,
  output logic        o_mem_we,
  output logic [19:0] o_mem_addr,
  output logic [15:0] o_data_to_sram,
  output logic        o_drive_en,
  input  logic [15:0] i_data_from_sram
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e      r_state, w_state;
  logic        r_we, w_we;
  logic [19:0] r_addr, w_addr;
  logic [15:0] r_wdata, w_wdata;
  logic        r_gnt, w_gnt;
  logic [3:0]  r_cnt, w_cnt;
  logic [15:0] r_rdata, w_rdata;
  logic        w_win;

  // Reset leaves r_gnt = 1 so that port 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_gnt   <= 1'b1;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_gnt   <= w_gnt;
      r_cnt   <= w_cnt;
      r_rdata <= w_rdata;
    end
  end

  // Round-robin: a lone requester wins; on a tie the port that did not own
  // the last transaction wins.
  assign w_win = (i_req0 && i_req1) ? ~r_gnt : i_req1;

  always_comb begin
    w_state = r_state;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_gnt   = r_gnt;
    w_cnt   = r_cnt;
    w_rdata = r_rdata;
    unique case (r_state)
      StIdle: begin
        if (i_req0 || i_req1) begin
          w_gnt   = w_win;
          w_we    = w_win ? i_we1 : i_we0;
          w_addr  = w_win ? i_addr1 : i_addr0;
          w_wdata = w_win ? i_wdata1 : i_wdata0;
          w_cnt   = LP_WAIT;
          w_state = StAccess;
        end
      end
      StAccess: begin
        w_cnt = r_cnt - 4'd1;
        // Last ACCESS edge: read data has had the full strobe time to settle.
        if (r_cnt == 4'd1) begin
          w_state = StDone;
          if (!r_we) begin
            w_rdata = i_data_from_sram;
          end
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  // Moore outputs: strobes depend only on the state and latched direction,
  // so an asynchronous reset releases them immediately.
  always_comb begin
    o_mem_oe   = 1'b1;
    o_mem_we   = 1'b1;
    o_drive_en = 1'b0;
    o_ack0     = 1'b0;
    o_ack1     = 1'b0;
    unique case (r_state)
      StAccess: begin
        if (r_we) begin
          o_mem_we   = 1'b0;
          o_drive_en = 1'b1;
        end else begin
          o_mem_oe = 1'b0;
        end
      end
      StDone: begin
        o_ack0 = ~r_gnt;
        o_ack1 = r_gnt;
      end
      default: begin
      end
    endcase
  end

  assign o_mem_ce       = 1'b0;
  assign o_mem_ub       = 1'b0;
  assign o_mem_lb       = 1'b0;
  assign o_mem_addr     = r_addr;
  assign o_data_to_sram = r_wdata;
  assign o_rdata        = r_rdata;
  assign o_gnt          = r_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small SRAM model and a scoreboard of
// expected completions (port, direction, address, data).

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1, data_from_sram;
  logic        ack0, ack1, gnt, mem_ce, mem_ub, mem_lb, mem_oe, mem_we, drive_en;
  logic [15:0] rdata, data_to_sram;
  logic [19:0] mem_addr;

  // Extra instances for WAIT_CYCLES = 1 ([0]) and 15 ([1]).
  logic [1:0]  x_req, x_ack0, x_ack1, x_gnt, x_ce, x_ub, x_lb, x_oe, x_we, x_drv;
  logic [15:0] x_rdata [2];
  logic [15:0] x_dts   [2];
  logic [19:0] x_addr  [2];

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_gnt(gnt),
    .o_mem_ce(mem_ce), .o_mem_ub(mem_ub), .o_mem_lb(mem_lb), .o_mem_oe(mem_oe),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_data_to_sram(data_to_sram),
    .o_drive_en(drive_en), .i_data_from_sram(data_from_sram)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_req0(x_req[0]), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
    .i_addr0(20'h3), .i_addr1(20'h0), .i_wdata0(16'h0), .i_wdata1(16'h0),
    .o_ack0(x_ack0[0]), .o_ack1(x_ack1[0]), .o_rdata(x_rdata[0]), .o_gnt(x_gnt[0]),
    .o_mem_ce(x_ce[0]), .o_mem_ub(x_ub[0]), .o_mem_lb(x_lb[0]), .o_mem_oe(x_oe[0]),
    .o_mem_we(x_we[0]), .o_mem_addr(x_addr[0]), .o_data_to_sram(x_dts[0]),
    .o_drive_en(x_drv[0]), .i_data_from_sram(16'hA5A5)
  );

  mem_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .i_clk(clk), .i_rst(rst), .i_req0(x_req[1]), .i_req1(1'b0), .i_we0(1'b0), .i_we1(1'b0),
    .i_addr0(20'h3), .i_addr1(20'h0), .i_wdata0(16'h0), .i_wdata1(16'h0),
    .o_ack0(x_ack0[1]), .o_ack1(x_ack1[1]), .o_rdata(x_rdata[1]), .o_gnt(x_gnt[1]),
    .o_mem_ce(x_ce[1]), .o_mem_ub(x_ub[1]), .o_mem_lb(x_lb[1]), .o_mem_oe(x_oe[1]),
    .o_mem_we(x_we[1]), .o_mem_addr(x_addr[1]), .o_data_to_sram(x_dts[1]),
    .o_drive_en(x_drv[1]), .i_data_from_sram(16'hA5A5)
  );

  // SRAM model: 64 words, written on every edge of an active write strobe.
  logic [15:0] sram [64];
  logic        pl_we;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) sram[pl_addr] <= pl_data;
    else if (!mem_we && drive_en) sram[mem_addr[5:0]] <= data_to_sram;
  end
  assign data_from_sram = sram[mem_addr[5:0]];

  // Scoreboard.
  typedef struct {
    logic        port;
    logic        rd;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] shadow [64];
  logic        hold0, hold1;
  int          pass_cnt = 0;
  int          fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    shadow[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic push(input logic port, input logic rd, input logic [19:0] a,
                      input logic [15:0] wd);
    exp_t e;
    e.port = port; e.rd = rd; e.addr = a; e.wdata = wd; e.rdata = shadow[a[5:0]];
    if (!rd) shadow[a[5:0]] = wd;
    sb.push_back(e);
  endtask

  task automatic issue(input logic port, input logic rd, input logic [19:0] a,
                       input logic [15:0] wd);
    if (port) begin req1 = 1'b1; we1 = ~rd; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = ~rd; addr0 = a; wdata0 = wd; end
    push(port, rd, a, wd);
  endtask

  // Runs until n_acks completions (or budget cycles); cyc is the negedge
  // count at the last Ack, oe_lo/we_lo the strobe-low cycle counts.
  task automatic run(input int n_acks, input int budget, output int cyc,
                     output int oe_lo, output int we_lo);
    exp_t e;
    int   acks = 0;
    logic prev_ack = 1'b0;
    cyc = 0; oe_lo = 0; we_lo = 0;
    while (acks < n_acks && cyc < budget) begin
      @(negedge clk);
      cyc++;
      check("oe_we_exclusive", mem_oe | mem_we, 1);
      check("drive_only_when_we", drive_en & mem_we, 0);
      if (prev_ack) check("idle_gap_after_ack", mem_oe & mem_we, 1);
      if (!mem_oe) oe_lo++;
      if (!mem_we) we_lo++;
      if (sb.size() > 0 && (!mem_oe || !mem_we)) begin
        check("strobe_addr", mem_addr, sb[0].addr);
        check("strobe_dir", mem_we, sb[0].rd);
        if (drive_en) check("write_data", data_to_sram, sb[0].wdata);
      end
      prev_ack = ack0 | ack1;
      if (ack0 || ack1) begin
        acks++;
        if (sb.size() == 0) begin
          check("unexpected_ack", {ack1, ack0}, 0);
        end else begin
          e = sb.pop_front();
          check("ack_port", {ack1, ack0}, e.port ? 2'b10 : 2'b01);
          check("gnt", gnt, e.port);
          if (e.rd) check("rdata", rdata, e.rdata);
          if (e.port == 1'b0 && !hold0) req0 = 1'b0;
          if (e.port == 1'b1 && !hold1) req1 = 1'b0;
        end
      end
    end
    if (acks < n_acks) check("ack_timeout", acks, n_acks);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, oe_lo, we_lo;
    int c1, c15, oe1, oe15;
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; hold0 = 0; hold1 = 0; pl_we = 0; pl_addr = '0;
    pl_data = '0; x_req = 2'b00;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_oe", mem_oe, 1);
    check("rst_we", mem_we, 1);
    check("rst_drive", drive_en, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_gnt", gnt, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_ce_ub_lb", {mem_ce, mem_ub, mem_lb}, 0);

    preload(6'h10, 16'h1234);
    rst = 1'b0;

    // Read port 0: Ack at k+3, OE low two cycles.
    issue(0, 1, 20'h00010, 16'h0);
    run(1, 10, cyc, oe_lo, we_lo);
    check("rd0_latency", cyc, 3);
    check("rd0_oe_width", oe_lo, 2);
    check("rd0_we_width", we_lo, 0);
    check("rd0_rdata", rdata, 16'h1234);
    check("rd0_gnt", gnt, 0);

    // Write port 1.
    @(negedge clk);
    issue(1, 0, 20'h00020, 16'hBEEF);
    run(1, 10, cyc, oe_lo, we_lo);
    check("wr1_latency", cyc, 3);
    check("wr1_we_width", we_lo, 2);
    check("wr1_oe_width", oe_lo, 0);

    // Read back; request inputs are scrambled mid-transaction and must be ignored.
    @(negedge clk);
    issue(0, 1, 20'h00020, 16'h0);
    @(negedge clk);
    addr0 = 20'h0003F; we0 = 1'b1; wdata0 = 16'hDEAD;
    run(1, 10, cyc, oe_lo, we_lo);
    check("rdback_latency", cyc, 2);
    check("rdback_rdata", rdata, 16'hBEEF);

    // Both requesting from reset: port 0 first, then port 1.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("tie_rst_gnt", gnt, 1);
    issue(0, 1, 20'h00010, 16'h0);
    issue(1, 1, 20'h00020, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    run(2, 20, cyc, oe_lo, we_lo);
    check("tie1_cycles", cyc, 7);

    // Repeated tie alternates again.
    @(negedge clk);
    issue(0, 1, 20'h00010, 16'h0);
    issue(1, 1, 20'h00020, 16'h0);
    run(2, 20, cyc, oe_lo, we_lo);
    check("tie2_cycles", cyc, 7);

    // Both held continuously: grants 0,1,0,1.
    @(negedge clk);
    issue(0, 1, 20'h00010, 16'h0);
    issue(1, 1, 20'h00020, 16'h0);
    push(0, 1, 20'h00010, 16'h0);
    push(1, 1, 20'h00020, 16'h0);
    hold0 = 1'b1; hold1 = 1'b1;
    run(4, 40, cyc, oe_lo, we_lo);
    check("hold_cycles", cyc, 15);
    check("hold_oe_width", oe_lo, 8);
    req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;

    // Reset during the second ACCESS cycle of a write aborts it.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00030; wdata1 = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    check("abort_we_before", mem_we, 0);
    #2 rst = 1'b1; req1 = 1'b0;
    #1;
    check("abort_we_released", mem_we, 1);
    check("abort_oe", mem_oe, 1);
    check("abort_drive", drive_en, 0);
    check("abort_ack", {ack1, ack0}, 0);
    check("abort_gnt", gnt, 1);
    check("abort_addr", mem_addr, 0);
    check("abort_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ack", {ack1, ack0}, 0);
    end
    issue(0, 1, 20'h00010, 16'h0);
    run(1, 10, cyc, oe_lo, we_lo);
    check("post_abort_latency", cyc, 3);

    // WAIT_CYCLES = 1 and 15.
    @(negedge clk);
    x_req = 2'b11; c1 = 0; c15 = 0; oe1 = 0; oe15 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!x_oe[0]) oe1++;
      if (!x_oe[1]) oe15++;
      if (x_ack0[0] && c1 == 0) begin c1 = c; x_req[0] = 1'b0; end
      if (x_ack0[1] && c15 == 0) begin c15 = c; x_req[1] = 1'b0; end
    end
    check("w1_latency", c1, 2);
    check("w15_latency", c15, 16);
    check("w1_oe_width", oe1, 1);
    check("w15_oe_width", oe15, 15);
    check("w1_rdata", x_rdata[0], 16'hA5A5);
    check("w15_rdata", x_rdata[1], 16'hA5A5);
    check("wx_gnt", x_gnt, 2'b00);
    check("wx_idle_strobes", {x_we, x_drv, x_ack1}, 6'b110000);
    check("wx_ce_ub_lb", {x_ce, x_ub, x_lb}, 0);
    check("wx_addr", {x_addr[1], x_addr[0]}, {20'h3, 20'h3});
    check("wx_wdata", {x_dts[1], x_dts[0]}, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
